// File: rtl/aemb_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory system (slave).
// Signal names keep the bus-side _o/_i direction as seen from the LSU.
interface aemb_lsu_if #(
  parameter int unsigned DSIZ = 32
);
  logic [DSIZ-1:0] dwb_adr_o;
  logic [31:0]     dwb_dat_o;
  logic [3:0]      dwb_sel_o;
  logic            dwb_stb_o;
  logic            dwb_we_o;
  logic [31:0]     dwb_dat_i;
  logic            dwb_ack_i;

  modport master (
    output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_stb_o, dwb_we_o,
    input  dwb_dat_i, dwb_ack_i
  );

  modport slave (
    input  dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_stb_o, dwb_we_o,
    output dwb_dat_i, dwb_ack_i
  );
endinterface

// File: rtl/aemb_lsu.sv
// Load/store unit: one big-endian byte/half/word bus cycle per request, stalls via drun.
// Optional ack timeout enabled by defining AEMB_LSU_TIMEOUT_EN.
module aemb_lsu #(
  parameter int unsigned DSIZ = 32,
  parameter int unsigned TOUT = 255
) (
  input  logic        nclk,
  input  logic        nrst,
  input  logic [1:0]  rMXLDST,
  input  logic [1:0]  rSIZE,
  input  logic [31:0] rRESULT,
  input  logic [31:0] rREGD,
  aemb_lsu_if.master  dwb,
  output logic        drun,
  output logic [31:0] rLDDAT,
  output logic        rLDVLD,
  output logic        rMISALIGN,
  output logic        rDWBERR
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [DSIZ-1:0] adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     lddat_q, lddat_d;
  logic            ldvld_q, ldvld_d;
  logic            misalign_q, misalign_d;

`ifdef AEMB_LSU_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TOUT + 1) > 8) ? $clog2(TOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dwberr_q, dwberr_d;
`endif

  logic [1:0]  a;
  logic        req;
  logic        aligned;
  logic [3:0]  sel_new;
  logic [31:0] dat_new;
  logic [31:0] lane;

  assign a   = rRESULT[1:0];
  assign req = (rMXLDST == 2'b01) || (rMXLDST == 2'b10);

  always_comb begin
    aligned = 1'b1;
    sel_new = 4'b1111;
    dat_new = rREGD;
    case (rSIZE)
      2'b00: begin
        sel_new = 4'b1000 >> a;
        dat_new = {4{rREGD[7:0]}};
      end
      2'b01: begin
        aligned = ~a[0];
        sel_new = a[1] ? 4'b0011 : 4'b1100;
        dat_new = {2{rREGD[15:0]}};
      end
      default: aligned = (a == 2'b00);
    endcase
  end

  // Big-endian lane pick: byte offset 0 lives in bits [31:24].
  always_comb begin
    lane = dwb.dwb_dat_i;
    case (size_q)
      2'b00:   lane = {24'b0, 8'(dwb.dwb_dat_i >> {~off_q, 3'b000})};
      2'b01:   lane = off_q[1] ? {16'b0, dwb.dwb_dat_i[15:0]} : {16'b0, dwb.dwb_dat_i[31:16]};
      default: lane = dwb.dwb_dat_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    we_d       = we_q;
    off_d      = off_q;
    size_d     = size_q;
    lddat_d    = lddat_q;
    ldvld_d    = 1'b0;
    misalign_d = 1'b0;
    drun       = 1'b1;
`ifdef AEMB_LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    dwberr_d   = dwberr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (aligned) begin
            adr_d   = {rRESULT[DSIZ-1:2], 2'b00};
            sel_d   = sel_new;
            dat_d   = dat_new;
            we_d    = (rMXLDST == 2'b10);
            stb_d   = 1'b1;
            off_d   = a;
            size_d  = rSIZE;
            drun    = 1'b0;
            state_d = StBusy;
`ifdef AEMB_LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      StBusy: begin
        drun = 1'b0;
        if (dwb.dwb_ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
          state_d = StDone;
          if (!we_q) begin
            lddat_d = lane;
            ldvld_d = 1'b1;
          end
        end
`ifdef AEMB_LSU_TIMEOUT_EN
        else if (cnt_q == CntW'(TOUT - 1)) begin
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = 4'b0000;
          dwberr_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge nclk) begin
    if (nrst) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      lddat_q    <= '0;
      ldvld_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      off_q      <= off_d;
      size_q     <= size_d;
      lddat_q    <= lddat_d;
      ldvld_q    <= ldvld_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef AEMB_LSU_TIMEOUT_EN
  always_ff @(negedge nclk) begin
    if (nrst) begin
      cnt_q    <= '0;
      dwberr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dwberr_q <= dwberr_d;
    end
  end
  assign rDWBERR = dwberr_q;
`else
  assign rDWBERR = 1'b0;
`endif

  assign dwb.dwb_adr_o = adr_q;
  assign dwb.dwb_dat_o = dat_q;
  assign dwb.dwb_sel_o = sel_q;
  assign dwb.dwb_stb_o = stb_q;
  assign dwb.dwb_we_o  = we_q;
  assign rLDDAT        = lddat_q;
  assign rLDVLD        = ldvld_q;
  assign rMISALIGN     = misalign_q;

endmodule
